// File: rtl/pio_edge_irq_pkg.sv
// Shared constants for the edge/level interrupt input PIO.
// Register word addresses and the debounce-limit reset value.
package pio_edge_irq_pkg;

   localparam logic [2:0] ADDR_DATA  = 3'd0;
   localparam logic [2:0] ADDR_RISE  = 3'd1;
   localparam logic [2:0] ADDR_MASK  = 3'd2;
   localparam logic [2:0] ADDR_CAPT  = 3'd3;
   localparam logic [2:0] ADDR_FALL  = 3'd4;
   localparam logic [2:0] ADDR_LEVEL = 3'd5;
   localparam logic [2:0] ADDR_DBLIM = 3'd6;

   localparam logic [31:0] DBLIM_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/pio_in_conditioner.sv
// One input bit: synchroniser chain plus optional debounce filter.
// The filter is built only when PIO_DEBOUNCE_EN is defined.
module pio_in_conditioner
   import pio_edge_irq_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DB_W        = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            pin,
   input  logic [DB_W-1:0] db_limit,
   output logic            f
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync <= '0;
      else          sync <= {sync[SYNC_STAGES-2:0], pin};
   end

   assign s = sync[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
   logic [DB_W-1:0] cnt;
   logic            f_q;

   // f only follows s once s has disagreed for db_limit+1 clocks
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         f_q <= 1'b0;
      end else if (s == f_q) begin
         cnt <= '0;
      end else if (cnt == db_limit) begin
         f_q <= s;
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign f = f_q;
`else
   logic unused_db;
   assign unused_db = ^db_limit;
   assign f = s;
`endif

endmodule

// File: rtl/pio_edge_irq.sv
// Avalon-MM input PIO with per-bit rise/fall/level interrupts.
// Optional debounce filter enabled by defining PIO_DEBOUNCE_EN.
module pio_edge_irq
   import pio_edge_irq_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DB_W        = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] f;
   logic [WIDTH-1:0] f_d;
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;
   logic [WIDTH-1:0] level_en;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] capture;
   logic [WIDTH-1:0] eff;
   logic [WIDTH-1:0] set;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] wd;
   logic [DB_W-1:0]  db_limit;
   logic [31:0]      rd;
   logic             wr;
   logic             unused_wd;

   assign wr        = chipselect & ~write_n;
   assign wd        = writedata[WIDTH-1:0];
   assign unused_wd = ^writedata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cond
      pio_in_conditioner #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_W        (DB_W)
      ) u_cond (
         .clk      (clk),
         .reset_n  (reset_n),
         .pin      (in_port[i]),
         .db_limit (db_limit),
         .f        (f[i])
      );
   end

   assign set = (f & ~f_d & rise_en)
              | (~f & f_d & fall_en);

   // level bits ignore W1C; set wins over a same-cycle clear
   assign clr = (wr && address == ADDR_CAPT)
              ? (wd & ~level_en) : '0;

   assign eff = (level_en & f) | (~level_en & capture);
   assign irq = |(eff & irq_mask);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         f_d      <= '0;
         rise_en  <= '0;
         fall_en  <= '0;
         level_en <= '0;
         irq_mask <= '0;
         capture  <= '0;
      end else begin
         f_d     <= f;
         capture <= set | (capture & ~clr);
         if (wr) begin
            case (address)
               ADDR_RISE:  rise_en  <= wd;
               ADDR_MASK:  irq_mask <= wd;
               ADDR_FALL:  fall_en  <= wd;
               ADDR_LEVEL: level_en <= wd;
               default: ;
            endcase
         end
      end
   end

`ifdef PIO_DEBOUNCE_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         db_limit <= DBLIM_RST[DB_W-1:0];
      else if (wr && address == ADDR_DBLIM)
         db_limit <= writedata[DB_W-1:0];
   end
`else
   assign db_limit = '0;
`endif

   always_comb begin
      rd = '0;
      case (address)
         ADDR_DATA:  rd[WIDTH-1:0] = f;
         ADDR_RISE:  rd[WIDTH-1:0] = rise_en;
         ADDR_MASK:  rd[WIDTH-1:0] = irq_mask;
         ADDR_CAPT:  rd[WIDTH-1:0] = eff;
         ADDR_FALL:  rd[WIDTH-1:0] = fall_en;
         ADDR_LEVEL: rd[WIDTH-1:0] = level_en;
`ifdef PIO_DEBOUNCE_EN
         ADDR_DBLIM: rd[DB_W-1:0]  = db_limit;
`endif
         default:    rd = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= rd;
   end

endmodule

// File: tb/tb_pio_edge_irq.sv
// Directed scoreboard bench for pio_edge_irq (WIDTH=8, 2 sync stages).
// Reads and irq checks queue expectations; a monitor compares them.
module tb_pio_edge_irq;
   import pio_edge_irq_pkg::*;

   typedef struct {
      bit          is_irq;
      logic [31:0] exp;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [7:0]  in_port;
   logic [31:0] readdata;
   logic        irq;

   exp_t        sb[$];
   logic        chk_req = 1'b0;
   int          n_vec = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   pio_edge_irq #(
      .WIDTH       (8),
      .SYNC_STAGES (2),
      .DB_W        (8)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   // monitor: output is valid #1 after the edge that follows a request
   always @(posedge clk) begin
      if (chk_req) begin
         exp_t        e;
         logic [31:0] act;
         #1;
         n_vec++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_underflow");
         end else begin
            e   = sb.pop_front();
            act = e.is_irq ? {31'b0, irq} : readdata;
            if (act !== e.exp) begin
               n_bad++;
               $display("FAIL %s: got %h want %h",
                        e.name, act, e.exp);
            end
         end
      end
   end

   // all tasks start and end on a falling edge, one clock each
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drv(input logic [7:0] v);
      in_port = v;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] e,
                     input string nm);
      exp_t x;
      x.is_irq = 1'b0;
      x.exp    = e;
      x.name   = nm;
      sb.push_back(x);
      address = a;
      chk_req = 1'b1;
      @(negedge clk);
      chk_req = 1'b0;
   endtask

   task automatic ck_irq(input logic e, input string nm);
      exp_t x;
      x.is_irq = 1'b1;
      x.exp    = {31'b0, e};
      x.name   = nm;
      sb.push_back(x);
      chk_req = 1'b1;
      @(negedge clk);
      chk_req = 1'b0;
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // reset defaults
      rd(ADDR_DATA,  32'h0, "rst_data");
      rd(ADDR_RISE,  32'h0, "rst_rise");
      rd(ADDR_MASK,  32'h0, "rst_mask");
      rd(ADDR_CAPT,  32'h0, "rst_capt");
      rd(ADDR_FALL,  32'h0, "rst_fall");
      rd(ADDR_LEVEL, 32'h0, "rst_level");
`ifdef PIO_DEBOUNCE_EN
      rd(ADDR_DBLIM, 32'hFF, "rst_dblim");
`else
      rd(ADDR_DBLIM, 32'h0, "rst_dblim");
`endif
      rd(3'd7, 32'h0, "rst_resv");
      ck_irq(1'b0, "rst_irq");

`ifdef PIO_DEBOUNCE_EN
      wr(ADDR_DBLIM, 32'd0);
      rd(ADDR_DBLIM, 32'h0, "dblim_zero");
`endif

      // falling edge on bit 0
      drv(8'h01);
      idle(6);
      rd(ADDR_CAPT, 32'h0, "fall_no_rise");
      wr(ADDR_FALL, 32'h01);
      wr(ADDR_MASK, 32'h01);
      drv(8'h00);
      ck_irq(1'b0, "fall_lat1");
      ck_irq(1'b0, "fall_lat2");
      ck_irq(1'b1, "fall_lat3");
      rd(ADDR_CAPT, 32'h01, "fall_capt");
      wr(ADDR_CAPT, 32'h01);
      ck_irq(1'b0, "fall_clr_irq");
      rd(ADDR_DATA, 32'h00, "fall_data");

      // any-edge on bit 7
      wr(ADDR_RISE, 32'h80);
      wr(ADDR_FALL, 32'h80);
      wr(ADDR_MASK, 32'h80);
      drv(8'h80);
      idle(4);
      rd(ADDR_CAPT, 32'h80, "any_rise");
      ck_irq(1'b1, "any_irq");
      wr(ADDR_CAPT, 32'h80);
      rd(ADDR_CAPT, 32'h00, "any_clr");
      idle(2);
      drv(8'h00);
      idle(4);
      rd(ADDR_CAPT, 32'h80, "any_fall");
      wr(ADDR_CAPT, 32'h80);
      ck_irq(1'b0, "any_irq_off");

      // W1C on the same clock as set[3]
      wr(ADDR_RISE, 32'h08);
      drv(8'h08);
      idle(2);
      wr(ADDR_CAPT, 32'h08);
      rd(ADDR_CAPT, 32'h08, "collide_keep");
      wr(ADDR_CAPT, 32'h08);
      rd(ADDR_CAPT, 32'h00, "collide_clr");
      drv(8'h00);
      idle(4);

      // level mode on bit 2
      wr(ADDR_LEVEL, 32'h04);
      wr(ADDR_MASK,  32'h04);
      drv(8'h04);
      idle(2);
      ck_irq(1'b1, "lvl_irq");
      rd(ADDR_CAPT, 32'h04, "lvl_capt");
      wr(ADDR_CAPT, 32'h04);
      ck_irq(1'b1, "lvl_w1c_nop");
      drv(8'h00);
      idle(2);
      ck_irq(1'b0, "lvl_release");
      rd(ADDR_CAPT, 32'h00, "lvl_capt0");

      // register readback and upper-bit masking
      wr(ADDR_MASK, 32'hFFFF_FF04);
      rd(ADDR_MASK,  32'h04, "mask_width");
      rd(ADDR_RISE,  32'h08, "rise_rb");
      rd(ADDR_FALL,  32'h80, "fall_rb");
      rd(ADDR_LEVEL, 32'h04, "level_rb");

      // asynchronous reset mid-operation
      wr(ADDR_RISE, 32'h01);
      drv(8'h01);
      idle(4);
      rd(ADDR_CAPT, 32'h01, "pre_rst_capt");
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      rd(ADDR_CAPT,  32'h0, "post_rst_capt");
      rd(ADDR_RISE,  32'h0, "post_rst_rise");
      rd(ADDR_LEVEL, 32'h0, "post_rst_level");

`ifdef PIO_DEBOUNCE_EN
      // debounce with db_limit=5 on bit 1
      wr(ADDR_DBLIM, 32'd5);
      drv(8'h00);
      idle(12);
      wr(ADDR_RISE, 32'h02);
      drv(8'h02);
      idle(4);
      drv(8'h00);
      idle(12);
      rd(ADDR_CAPT, 32'h00, "db_glitch_capt");
      rd(ADDR_DATA, 32'h00, "db_glitch_data");
      drv(8'h02);
      idle(7);
      drv(8'h00);
      idle(1);
      rd(ADDR_DATA, 32'h02, "db_pulse_data");
      idle(10);
      rd(ADDR_CAPT, 32'h02, "db_pulse_capt");
`endif

      idle(2);
      if (sb.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL scoreboard_left: got %0d want 0",
                  sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pio_edge_irq.md
Name: pio_edge_irq

Overview:
- Parametrised Avalon-MM input PIO with per-bit interrupt generation. Successor to the single-bit falling-edge input port used for touch-controller nIRQ lines.
- Synchroniser depth and port width are parametrised. Each bit independently selects rising, falling, both-edge or level-sensitive interrupts.
- Capture register is per-bit write-1-to-clear.
- Sits between board-level interrupt/status pins (touch nIRQ, SD card-detect, keys) and the Nios II interrupt controller.

Parameters:
- WIDTH, 8, number of input bits (1..32).
- SYNC_STAGES, 2, synchroniser flip-flops per bit (2..4).
- DB_W, 8, debounce counter width; used only with PIO_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low; clock clk.
- address  in  3  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt to the CPU.

Behaviour:
- **Reset values:**
  - readdata=0.
  - All sync/filter flops=0.
  - rise_en=0, fall_en=0, level_en=0, irq_mask=0, edge_capture=0.
  - db_limit=all ones.
  - irq=0.
- **Register map** (bits above WIDTH read 0, writes to them ignored):
  - 0 data (RO): conditioned input f.
  - 1 rise_en (RW).
  - 2 irq_mask (RW).
  - 3 edge_capture (R / W1C).
  - 4 fall_en (RW).
  - 5 level_en (RW).
  - 6 db_limit (RW, low DB_W bits).
  - 7 reserved, reads 0.
- **Read timing:** readdata is registered every cycle from the current address, independent of chipselect. Read latency is 1 clock.
- **Write:** takes effect on the clock edge where chipselect & ~write_n.
- **Conditioning:** in_port passes through SYNC_STAGES flops to give s; s drives f (directly, or via the debounce filter). f_d is f delayed by one cycle.
- **Edge detect:**
  - rise = f & ~f_d.
  - fall = ~f & f_d.
  - set = (rise & rise_en) | (fall & fall_en).
  - Both enables set on a bit gives any-edge.
- **edge_capture[i] update:**
  - If set[i]: becomes 1.
  - Else if a W1C write has writedata[i]=1: becomes 0.
  - Else: holds.
  - A simultaneous edge and clear leaves the bit set; no event is lost.
- **Level mode (level_en[i]=1):**
  - The effective capture bit is f[i]; the sticky bit is ignored for irq.
  - Address 3 reads f[i] for that bit.
  - W1C writes have no effect on that bit.
- **irq** = |(eff_capture & irq_mask). Combinational from registers, no added latency.
- **Latency:** an edge on in_port reaches irq after SYNC_STAGES+1 clocks (no debounce).
- **Input high at reset release:** produces a rising event after synchronisation. Firmware clears edge_capture before unmasking.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronous); no pending events survive.

Optional Feature:
- Macro: PIO_DEBOUNCE_EN.
- **Defined:** a per-bit DB_W counter filters the signal.
  - While s[i]==f[i], the counter is 0.
  - While s[i]!=f[i], the counter increments.
  - When counter==db_limit, f[i] takes s[i] and the counter returns to 0.
  - A pulse shorter than db_limit+1 clocks is rejected.
  - db_limit=0 gives a 1-cycle filter.
  - Adds db_limit+1 clocks of latency.
- **Undefined:**
  - f=s.
  - Address 6 reads 0, writes ignored.
  - No counters are synthesised.

Decomposition:
- Package pio_edge_irq_pkg:
  - Address constants ADDR_DATA, ADDR_RISE, ADDR_MASK, ADDR_CAPT, ADDR_FALL, ADDR_LEVEL, ADDR_DBLIM.
  - Reset constant for db_limit.
- Sub-module pio_in_conditioner: one bit of synchroniser plus optional debounce, parametrised SYNC_STAGES/DB_W, instantiated WIDTH times by generate.
- The top level holds the register file, edge logic, read mux and irq.

Test Plan:
- **Reset defaults:** reset, read all 8 addresses -> all 0 except address 6 = 0xFF (with debounce); irq=0.
- **Falling edge:** WIDTH=8, fall_en=0x01, mask=0x01; drive in_port[0] 1->0 -> edge_capture=0x01 and irq=1 within SYNC_STAGES+1 clocks. Write 0x01 to address 3 -> irq=0.
- **Any-edge:** rise_en=fall_en=0x80, mask=0x80; pulse in_port[7] high for 10 clocks -> capture sets on both edges. A clear written between the edges re-sets on the second edge.
- **Clear/edge collision:** schedule a W1C to bit 3 on the same clock that set[3] asserts -> edge_capture[3] stays 1.
- **Level mode:** level_en=0x04, mask=0x04; hold in_port[2]=1 -> irq=1. W1C has no effect. Release input -> irq=0 after sync latency.
- **Debounce (PIO_DEBOUNCE_EN):** db_limit=5. A 4-clock glitch -> no capture, data unchanged. A 7-clock pulse -> data follows and capture sets.
